// File: rtl/vga1306_frame_tx.sv
// VGA1306 pixel-write transmitter: streams a 2^ADDR_WIDTH-pixel frame store over wclk/write_en/din/cs.
// Optional macro VGA1306_TX_CONTINUOUS_EN adds input continuous for back-to-back frames.
//
// state    | meaning
// IDLE     | cs high, waiting for start
// CS_SETUP | cs low, wclk low for H cycles before the sync pulse
// SYNC     | one wclk pulse with write_en=0 (receiver address reset)
// DATA     | one wclk pulse per pixel with write_en=1
// CS_HOLD  | wclk low, cs still low for H cycles, then done
// GAP      | one cycle with cs high between continuous frames
module vga1306_frame_tx #(
    parameter int ADDR_WIDTH  = 13,
    parameter int DATA_WIDTH  = 2,
    parameter int HALF_PERIOD = 2
) (
    input  logic                  CLK25MHz,
    input  logic                  reset,
    input  logic                  start,
`ifdef VGA1306_TX_CONTINUOUS_EN
    input  logic                  continuous,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] fb_raddr,
    input  logic [DATA_WIDTH-1:0] fb_rdata,
    output logic                  wclk,
    output logic                  write_en,
    output logic [DATA_WIDTH-1:0] din,
    output logic                  cs
);

    localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CW-1:0]       C_HLAST = CW'(HALF_PERIOD - 1);
    localparam logic [ADDR_WIDTH:0] C_NPIX  = {1'b1, {ADDR_WIDTH{1'b0}}};

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SYNC  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
`ifdef VGA1306_TX_CONTINUOUS_EN
    localparam logic [2:0] S_GAP   = 3'd5;
`endif

    logic [2:0]            r_state;
    logic [CW-1:0]         r_hcnt;
    logic [ADDR_WIDTH:0]   r_pix;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic [DATA_WIDTH-1:0] r_din;
    logic                  r_we;
    logic                  r_wclk;
    logic                  r_cs;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_hwrap;
    logic                  w_cnt_idle;

    assign w_hwrap = (r_hcnt == C_HLAST);

    // The half-period counter is parked at zero outside timed phases so each phase starts aligned.
`ifdef VGA1306_TX_CONTINUOUS_EN
    assign w_cnt_idle = (r_state == S_IDLE) || (r_state == S_GAP);
`else
    assign w_cnt_idle = (r_state == S_IDLE);
`endif

    always_ff @(posedge CLK25MHz or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_hcnt  <= '0;
            r_pix   <= '0;
            r_raddr <= '0;
            r_din   <= '0;
            r_we    <= 1'b0;
            r_wclk  <= 1'b0;
            r_cs    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_cnt_idle || w_hwrap) begin
                r_hcnt <= '0;
            end else begin
                r_hcnt <= r_hcnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_SETUP;
                        r_cs    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_raddr <= '0;
                        r_pix   <= '0;
                    end
                end
                S_SETUP: begin
                    if (w_hwrap) begin
                        r_state <= S_SYNC;
                    end
                end
                S_SYNC: begin
                    if (w_hwrap) begin
                        if (!r_wclk) begin
                            r_wclk <= 1'b1;
                        end else begin
                            // fb_raddr has been 0 all through SYNC, so fb_rdata is pixel 0.
                            r_wclk  <= 1'b0;
                            r_state <= S_DATA;
                            r_din   <= fb_rdata;
                            r_we    <= 1'b1;
                            r_raddr <= r_raddr + 1'b1;
                            r_pix   <= r_pix + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_hwrap) begin
                        if (!r_wclk) begin
                            r_wclk <= 1'b1;
                        end else begin
                            r_wclk <= 1'b0;
                            if (r_pix == C_NPIX) begin
                                r_state <= S_HOLD;
                                r_we    <= 1'b0;
                                r_din   <= '0;
                            end else begin
                                r_din   <= fb_rdata;
                                r_raddr <= r_raddr + 1'b1;
                                r_pix   <= r_pix + 1'b1;
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (w_hwrap) begin
                        r_cs   <= 1'b1;
                        r_done <= 1'b1;
`ifdef VGA1306_TX_CONTINUOUS_EN
                        if (continuous) begin
                            r_state <= S_GAP;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
`else
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
`endif
                    end
                end
`ifdef VGA1306_TX_CONTINUOUS_EN
                S_GAP: begin
                    r_state <= S_SETUP;
                    r_cs    <= 1'b0;
                    r_raddr <= '0;
                    r_pix   <= '0;
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign fb_raddr = r_raddr;
    assign wclk     = r_wclk;
    assign write_en = r_we;
    assign din      = r_din;
    assign cs       = r_cs;

endmodule

// File: tb/tb_vga1306_frame_tx.sv
// Bench for vga1306_frame_tx: two instances (H=1 and H=3) each with a frame store and receiver model.
module tb_vga1306_frame_tx;

    logic       clk = 1'b0;
    logic [1:0] rst_v;
    logic [1:0] start_v;
    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_mon
        localparam int HK = (k == 0) ? 1 : 3;
        logic        busy, done, wclk, we, cs;
        logic [12:0] raddr;
        logic [1:0]  rdata, din;
        int          exp_edges[$];
        int          exp_done[$];
        int          done_cnt = 0;
        int          edges    = 0;
        int          stab     = 0;
        int          rx_addr  = 0;
        logic        pwclk = 1'b0, pcs = 1'b1, pwe = 1'b0;
        logic [1:0]  pdin = 2'b00;
        logic [1:0]  mem [8192];
        bit          wr  [8192];

        vga1306_frame_tx #(.ADDR_WIDTH(13), .DATA_WIDTH(2), .HALF_PERIOD(HK)) u_dut (
            .CLK25MHz (clk),
            .reset    (rst_v[k]),
            .start    (start_v[k]),
`ifdef VGA1306_TX_CONTINUOUS_EN
            .continuous(1'b0),
`endif
            .busy     (busy),
            .done     (done),
            .fb_raddr (raddr),
            .fb_rdata (rdata),
            .wclk     (wclk),
            .write_en (we),
            .din      (din),
            .cs       (cs)
        );

        // frame store: pixel value is the low address bits, one cycle read latency
        always @(posedge clk) rdata <= raddr[1:0];

        always @(negedge clk) begin
            int exp_v;
            int bad;
            if ((din != pdin) || (we != pwe)) stab = 1;
            else stab = stab + 1;

            if (!cs && pcs) begin
                for (int i = 0; i < 8192; i++) wr[i] = 1'b0;
            end

            if (!cs && wclk && !pwclk) begin
                exp_v = (edges == 0) ? 0 : (4 | ((edges - 1) & 3));
                chk($sformatf("edge_we_din[%0d] idx=%0d", k, edges), int'({we, din}), exp_v);
                checks++;
                if (!(stab > HK)) begin
                    errors++;
                    $display("FAIL setup[%0d] idx=%0d: stable %0d cycles, need more than %0d", k, edges, stab - 1, HK - 1);
                end
                if (!we) begin
                    rx_addr = 0;
                end else begin
                    mem[rx_addr % 8192] = din;
                    wr[rx_addr % 8192]  = 1'b1;
                    rx_addr++;
                end
                edges++;
            end

            if (cs && !pcs) begin
                if (exp_edges.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame[%0d]: got %0d edges expected no frame", k, edges);
                end else begin
                    exp_v = exp_edges.pop_front();
                    chk($sformatf("frame_edges[%0d]", k), edges, exp_v);
                    if (exp_v == 8193) begin
                        bad = 0;
                        for (int i = 0; i < 8192; i++)
                            if (!wr[i] || (mem[i] != 2'(i))) bad++;
                        chk($sformatf("rx_mem_bad[%0d]", k), bad, 0);
                    end
                end
                edges = 0;
            end

            if (done) begin
                done_cnt++;
                if (exp_done.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done[%0d]: got done at cycle %0d expected none", k, cyc);
                end else begin
                    chk($sformatf("done_cycle[%0d]", k), cyc, exp_done.pop_front());
                end
                chk($sformatf("done_cs_busy[%0d]", k), int'({cs, busy}), 2);
            end

            pwclk = wclk;
            pcs   = cs;
            pwe   = we;
            pdin  = din;
        end
    end

    task automatic start_frame(input logic [1:0] mask, input int edges0);
        int s;
        s = cyc;
        start_v = mask;
        if (mask[0]) begin
            g_mon[0].exp_edges.push_back(edges0);
            if (edges0 == 8193) g_mon[0].exp_done.push_back(s + 1 + 16388 * 1);
        end
        if (mask[1]) begin
            g_mon[1].exp_edges.push_back(8193);
            g_mon[1].exp_done.push_back(s + 1 + 16388 * 3);
        end
        @(negedge clk);
        start_v = 2'b00;
        if (mask[0]) chk("busy_after_start[0]", int'(g_mon[0].busy), 1);
        if (mask[1]) chk("busy_after_start[1]", int'(g_mon[1].busy), 1);
    endtask

    initial begin
        int n;
        rst_v   = 2'b11;
        start_v = 2'b00;
        repeat (3) @(negedge clk);
        rst_v = 2'b00;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_outputs[0]", int'({g_mon[0].cs, g_mon[0].wclk, g_mon[0].we, g_mon[0].din,
                                          g_mon[0].busy, g_mon[0].done}), 64);
            chk("idle_outputs[1]", int'({g_mon[1].cs, g_mon[1].wclk, g_mon[1].we, g_mon[1].din,
                                          g_mon[1].busy, g_mon[1].done}), 64);
            chk("idle_raddr[0]", int'(g_mon[0].raddr), 0);
        end

        // full frame on both instances, with extra start pulses while busy
        start_frame(2'b11, 8193);
        repeat (3) @(negedge clk);
        start_v = 2'b11;
        @(negedge clk);
        start_v = 2'b00;
        repeat (94) @(negedge clk);
        start_v = 2'b11;
        @(negedge clk);
        start_v = 2'b00;

        n = 0;
        while (g_mon[0].done_cnt < 1 && n < 20000) begin @(negedge clk); n++; end
        chk("wait_done_frame1[0]", g_mon[0].done_cnt, 1);
        repeat (5) @(negedge clk);

        // abort mid-frame once pixel 4000 is loaded
        start_frame(2'b01, 4001);
        n = 0;
        while (g_mon[0].raddr != 13'd4001 && n < 20000) begin @(negedge clk); n++; end
        chk("reach_pixel4000[0]", int'(g_mon[0].raddr), 4001);
        rst_v[0] = 1'b1;
        #1;
        chk("async_reset_out[0]", int'({g_mon[0].cs, g_mon[0].wclk, g_mon[0].we, g_mon[0].din,
                                         g_mon[0].busy, g_mon[0].done}), 64);
        repeat (2) @(negedge clk);
        rst_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        start_frame(2'b01, 8193);
        n = 0;
        while (g_mon[0].done_cnt < 2 && n < 20000) begin @(negedge clk); n++; end
        chk("wait_done_frame3[0]", g_mon[0].done_cnt, 2);

        n = 0;
        while (g_mon[1].done_cnt < 1 && n < 60000) begin @(negedge clk); n++; end
        chk("wait_done_frame1[1]", g_mon[1].done_cnt, 1);
        repeat (20) @(negedge clk);

        chk("frames_pending[0]", g_mon[0].exp_edges.size(), 0);
        chk("frames_pending[1]", g_mon[1].exp_edges.size(), 0);
        chk("dones_pending[0]", g_mon[0].exp_done.size(), 0);
        chk("dones_pending[1]", g_mon[1].exp_done.size(), 0);
        chk("done_total[0]", g_mon[0].done_cnt, 2);
        chk("done_total[1]", g_mon[1].done_cnt, 1);
        chk("final_idle[0]", int'({g_mon[0].cs, g_mon[0].busy}), 2);
        chk("final_idle[1]", int'({g_mon[1].cs, g_mon[1].busy}), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
